seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIV, default 50000: clocks per digit slot; SHALL satisfy DIV >= 4.
REQ-002 Parameter GUARD, default 500: blanked clocks at the start of each slot; SHALL satisfy 1 <= GUARD < DIV.
REQ-003 Parameter BLANK_LZ, default 0: 1 enables leading-zero blanking.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 d1, d2, d3, d4  input  4 each  hex digits; d1 is the leftmost (most significant) digit.
REQ-007 dp  input  4  decimal-point request; dp[3] belongs to d1, dp[0] to d4; 1 = lit.
REQ-008 en  input  1  display enable; 0 blanks all anodes.
REQ-009 an  output  4  active-low anodes; an[3] = leftmost digit.
REQ-010 seg  output  7  active-low cathodes; seg[6:0] = g,f,e,d,c,b,a.
REQ-011 dp_n  output  1  active-low decimal point.

Function
REQ-012 The block SHALL hold a slot counter cnt (0..DIV-1) and a digit index idx (0..3).
- cnt increments every clock.
- At cnt == DIV-1, cnt wraps to 0 and idx advances 0->1->2->3->0.
REQ-013 Slot idx = k SHALL drive an[3-k] low and display shadow digit k (k = 0 is d1); all other anodes SHALL be high.
REQ-014 The block SHALL hold a shadow register {s1..s4, sdp}.
- Loads {d1..d4, dp} on the clock where cnt == DIV-1 and idx == 3, i.e. at frame wrap.
- A frame therefore never shows mixed old and new values, even if the inputs change mid-frame.
REQ-015 While cnt < GUARD, all anodes SHALL be high (ghosting guard).
REQ-016 an, seg and dp_n SHALL be registered outputs computed from the current cnt, idx and shadow, so they lag cnt/idx by exactly one clock.
REQ-017 Hex decode SHALL use this table, seg[6:0] in hex:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
REQ-018 dp_n SHALL be the inverse of sdp[3-idx] during a visible slot, and 1 otherwise.
REQ-019 With BLANK_LZ = 1, slot k < 3 SHALL keep all anodes high when shadow digits 0..k are all zero; slot 3 SHALL never be blanked by this rule.
REQ-020 When en = 0, an SHALL be 4'b1111 from the next clock; cnt, idx and shadow loading SHALL continue unaffected.
REQ-021 When en rises, display SHALL resume in the current slot with no counter restart.
REQ-022 Whenever all anodes are high, seg SHALL be 7'h7F and dp_n SHALL be 1.

Reset
REQ-023 rst = 0 SHALL asynchronously force the following, independent of clk:
- cnt = 0, idx = 0
- shadow = 0
- an = 4'hF, seg = 7'h7F, dp_n = 1
REQ-024 rst asserted mid-frame SHALL abort the frame; the first post-reset frame SHALL display zeros until the first frame-wrap load.
REQ-025 The first rising edge after rst deasserts SHALL be treated as a normal count edge (cnt 0 -> 1).

Verification (DIV = 8, GUARD = 2 unless stated)
REQ-026 Reset release with d = 1,2,3,4, en = 1 -> first frame: an pattern 7,B,D,E with seg = 40 in cycles 3..8 of each slot; the frame after wrap shows 79, 24, 30, 19 on an = 7, B, D, E.
REQ-027 Change d1 from 1 to F at mid-frame (idx = 1) -> current frame unchanged; seg = 0E on an = 7 only from the next frame.
REQ-028 dp = 4'b0010, d = 8,8,8,8 -> dp_n = 0 only while an = D; seg = 00 in every visible slot.
REQ-029 BLANK_LZ = 1, d = 0,0,5,0 -> slots 0 and 1 fully blank; slot 2 shows 12; slot 3 shows 40; input d = 0,0,0,0 -> only slot 3 lit with 40.
REQ-030 en dropped for 3 clocks during a visible slot -> an = F one clock after the fall, resumes one clock after the rise; idx timing identical to an en = 1 run.
REQ-031 rst pulsed low for less than one clock period mid-slot -> an = F and seg = 7F immediately; cnt restarts at 0; shadow = 0 until the next wrap.

Source files
------------

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with a frame-atomic shadow
// register, per-slot ghosting guard, optional leading-zero blanking and enable.
module seg_scan #(
  parameter int DIV      = 50000,
  parameter int GUARD    = 500,
  parameter int BLANK_LZ = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] dp,
  input  logic       en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp_n
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_idx;
  logic [3:0][3:0] r_sh;
  logic [3:0]      r_sdp;

  logic       w_wrap;
  logic       w_frameEnd;
  logic       w_lz;
  logic       w_vis;
  logic [3:0] w_digit;

  function automatic logic [6:0] hexToSeg(input logic [3:0] v);
    case (v)
      4'h0: hexToSeg = 7'h40;
      4'h1: hexToSeg = 7'h79;
      4'h2: hexToSeg = 7'h24;
      4'h3: hexToSeg = 7'h30;
      4'h4: hexToSeg = 7'h19;
      4'h5: hexToSeg = 7'h12;
      4'h6: hexToSeg = 7'h02;
      4'h7: hexToSeg = 7'h78;
      4'h8: hexToSeg = 7'h00;
      4'h9: hexToSeg = 7'h10;
      4'hA: hexToSeg = 7'h08;
      4'hB: hexToSeg = 7'h03;
      4'hC: hexToSeg = 7'h46;
      4'hD: hexToSeg = 7'h21;
      4'hE: hexToSeg = 7'h06;
      default: hexToSeg = 7'h0E;
    endcase
  endfunction

  assign w_wrap     = (r_cnt == CW'(DIV - 1));
  assign w_frameEnd = w_wrap && (r_idx == 2'd3);
  assign w_digit    = r_sh[r_idx];

  // A slot is suppressed when it and every digit to its left are zero;
  // the rightmost slot always shows so a value of zero is still visible.
  always_comb begin
    w_lz = 1'b0;
    if (BLANK_LZ != 0) begin
      case (r_idx)
        2'd0:    w_lz = (r_sh[0] == 4'h0);
        2'd1:    w_lz = ((r_sh[0] | r_sh[1]) == 4'h0);
        2'd2:    w_lz = ((r_sh[0] | r_sh[1] | r_sh[2]) == 4'h0);
        default: w_lz = 1'b0;
      endcase
    end
  end

  assign w_vis = en && (r_cnt >= CW'(GUARD)) && !w_lz;

  // Outputs are registered from the pre-edge counter state, so they trail cnt/idx by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
      r_sh  <= '0;
      r_sdp <= 4'h0;
      an    <= 4'hF;
      seg   <= 7'h7F;
      dp_n  <= 1'b1;
    end else begin
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_frameEnd) begin
        r_sh[0] <= d1;
        r_sh[1] <= d2;
        r_sh[2] <= d3;
        r_sh[3] <= d4;
        r_sdp   <= dp;
      end
      if (w_vis) begin
        an   <= ~(4'b1000 >> r_idx);
        seg  <= hexToSeg(w_digit);
        dp_n <= ~r_sdp[2'd3 - r_idx];
      end else begin
        an   <= 4'hF;
        seg  <= 7'h7F;
        dp_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: two instances (leading-zero blanking off/on) checked every
// clock against an edge-counting reference, plus decode table and corner sequences.
module tb_seg_scan;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d1, d2, d3, d4, dp;
  logic       en;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dpn0, dpn1;

  int errors = 0;
  int checks = 0;
  int n      = 0;

  logic [3:0] mSh [4];
  logic [3:0] mDp;

  typedef struct {
    logic [3:0] digit;
    logic [3:0] dpv;
    logic [6:0] expSeg;
    logic       expDpN;
  } vec_t;

  vec_t tbl [16];

  seg_scan #(.DIV(DIV), .GUARD(GUARD), .BLANK_LZ(0)) dut0 (
    .clk(clk), .rst(rst), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .dp(dp), .en(en),
    .an(an0), .seg(seg0), .dp_n(dpn0)
  );

  seg_scan #(.DIV(DIV), .GUARD(GUARD), .BLANK_LZ(1)) dut1 (
    .clk(clk), .rst(rst), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .dp(dp), .en(en),
    .an(an1), .seg(seg1), .dp_n(dpn1)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] refSeg(input logic [3:0] v);
    case (v)
      4'h0: refSeg = 7'h40; 4'h1: refSeg = 7'h79; 4'h2: refSeg = 7'h24; 4'h3: refSeg = 7'h30;
      4'h4: refSeg = 7'h19; 4'h5: refSeg = 7'h12; 4'h6: refSeg = 7'h02; 4'h7: refSeg = 7'h78;
      4'h8: refSeg = 7'h00; 4'h9: refSeg = 7'h10; 4'hA: refSeg = 7'h08; 4'hB: refSeg = 7'h03;
      4'hC: refSeg = 7'h46; 4'hD: refSeg = 7'h21; 4'hE: refSeg = 7'h06; default: refSeg = 7'h0E;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
    end
  endtask

  // Edge n (counted from reset release) falls in slot (n/DIV)%4 at position n%DIV.
  task automatic expectFor(input bit blank, output logic [3:0] eAn, output logic [6:0] eSeg,
                           output logic eDp);
    int c;
    int k;
    bit lz;
    bit vis;
    c  = n % DIV;
    k  = (n / DIV) % 4;
    lz = 1'b0;
    if (blank && k < 3) begin
      lz = 1'b1;
      for (int j = 0; j <= k; j++) if (mSh[j] != 4'h0) lz = 1'b0;
    end
    vis  = en && (c >= GUARD) && !lz;
    eAn  = vis ? ~(4'b1000 >> k) : 4'hF;
    eSeg = vis ? refSeg(mSh[k]) : 7'h7F;
    eDp  = vis ? ~mDp[2'(3 - k)] : 1'b1;
  endtask

  task automatic tick();
    logic [3:0] a0, a1;
    logic [6:0] s0, s1;
    logic       p0, p1;
    expectFor(1'b0, a0, s0, p0);
    expectFor(1'b1, a1, s1, p1);
    if (n % FRAME == FRAME - 1) begin
      mSh[0] = d1; mSh[1] = d2; mSh[2] = d3; mSh[3] = d4; mDp = dp;
    end
    @(posedge clk);
    #1;
    n++;
    checkOutput("an0",  16'(an0),  16'(a0));
    checkOutput("seg0", 16'(seg0), 16'(s0));
    checkOutput("dpn0", 16'(dpn0), 16'(p0));
    checkOutput("an1",  16'(an1),  16'(a1));
    checkOutput("seg1", 16'(seg1), 16'(s1));
    checkOutput("dpn1", 16'(dpn1), 16'(p1));
  endtask

  task automatic runTo(input int target);
    while (n < target) tick();
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                               input logic [3:0] d, input logic [3:0] p, input logic e);
    d1 = a; d2 = b; d3 = c; d4 = d; dp = p; en = e;
  endtask

  task automatic clearModel();
    n = 0;
    for (int j = 0; j < 4; j++) mSh[j] = 4'h0;
    mDp = 4'h0;
  endtask

  // Short low pulse between edges; outputs must blank without waiting for a clock.
  task automatic pulseReset();
    #2 rst = 1'b0;
    #1;
    checkOutput("rstPulse_an",  16'(an0),  16'hF);
    checkOutput("rstPulse_seg", 16'(seg0), 16'h7F);
    checkOutput("rstPulse_dpn", 16'(dpn0), 16'h1);
    #1 rst = 1'b1;
    clearModel();
  endtask

  initial begin
    for (int v = 0; v < 16; v++) begin
      tbl[v].digit  = 4'(v);
      tbl[v].dpv    = (v % 2 == 1) ? 4'b1000 : 4'b0111;
      tbl[v].expDpN = (v % 2 == 1) ? 1'b0 : 1'b1;
    end
    tbl[0].expSeg  = 7'h40; tbl[1].expSeg  = 7'h79; tbl[2].expSeg  = 7'h24; tbl[3].expSeg  = 7'h30;
    tbl[4].expSeg  = 7'h19; tbl[5].expSeg  = 7'h12; tbl[6].expSeg  = 7'h02; tbl[7].expSeg  = 7'h78;
    tbl[8].expSeg  = 7'h00; tbl[9].expSeg  = 7'h10; tbl[10].expSeg = 7'h08; tbl[11].expSeg = 7'h03;
    tbl[12].expSeg = 7'h46; tbl[13].expSeg = 7'h21; tbl[14].expSeg = 7'h06; tbl[15].expSeg = 7'h0E;

    rst = 1'b0;
    applyStimulus(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 1'b1);
    clearModel();
    #12;
    checkOutput("reset_an",   16'(an0),  16'hF);
    checkOutput("reset_seg",  16'(seg0), 16'h7F);
    checkOutput("reset_dpn",  16'(dpn0), 16'h1);
    checkOutput("reset_an1",  16'(an1),  16'hF);
    rst = 1'b1;

    // First frame shows the zeroed shadow; the loaded digits appear after wrap.
    runTo(2);             checkOutput("guard_an", 16'(an0), 16'hF);
    runTo(3);             checkOutput("f0s0_an", 16'(an0), 16'h7); checkOutput("f0s0_seg", 16'(seg0), 16'h40);
    runTo(8);             checkOutput("f0s0_end", 16'(an0), 16'h7);
    runTo(9);             checkOutput("f0s1_guard", 16'(an0), 16'hF);
    runTo(FRAME + 3);      checkOutput("f1s0_seg", 16'(seg0), 16'h79); checkOutput("f1s0_an", 16'(an0), 16'h7);
    runTo(FRAME + 11);     checkOutput("f1s1_seg", 16'(seg0), 16'h24); checkOutput("f1s1_an", 16'(an0), 16'hB);
    runTo(FRAME + 19);     checkOutput("f1s2_seg", 16'(seg0), 16'h30); checkOutput("f1s2_an", 16'(an0), 16'hD);
    runTo(FRAME + 27);     checkOutput("f1s3_seg", 16'(seg0), 16'h19); checkOutput("f1s3_an", 16'(an0), 16'hE);

    // d1 changes mid-frame; only the following frame may show it.
    runTo(2 * FRAME + 11);
    d1 = 4'hF;
    runTo(2 * FRAME + 27); checkOutput("midChg_s3", 16'(seg0), 16'h19);
    runTo(3 * FRAME + 3);  checkOutput("midChg_new", 16'(seg0), 16'h0E); checkOutput("midChg_an", 16'(an0), 16'h7);

    applyStimulus(4'h8, 4'h8, 4'h8, 4'h8, 4'b0010, 1'b1);
    runTo(4 * FRAME + 11); checkOutput("dp_s1_dpn", 16'(dpn0), 16'h1); checkOutput("dp_s1_seg", 16'(seg0), 16'h00);
    runTo(4 * FRAME + 19); checkOutput("dp_s2_dpn", 16'(dpn0), 16'h0); checkOutput("dp_s2_an", 16'(an0), 16'hD);

    applyStimulus(4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 1'b1);
    runTo(5 * FRAME + 3);  checkOutput("lz_s0_an", 16'(an1), 16'hF); checkOutput("lz_s0_seg", 16'(seg1), 16'h7F);
    checkOutput("nolz_s0_an", 16'(an0), 16'h7);
    runTo(5 * FRAME + 11); checkOutput("lz_s1_an", 16'(an1), 16'hF);
    runTo(5 * FRAME + 19); checkOutput("lz_s2_an", 16'(an1), 16'hD); checkOutput("lz_s2_seg", 16'(seg1), 16'h12);
    runTo(5 * FRAME + 27); checkOutput("lz_s3_an", 16'(an1), 16'hE); checkOutput("lz_s3_seg", 16'(seg1), 16'h40);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    runTo(6 * FRAME + 19); checkOutput("lz0_s2_an", 16'(an1), 16'hF);
    runTo(6 * FRAME + 27); checkOutput("lz0_s3_an", 16'(an1), 16'hE); checkOutput("lz0_s3_seg", 16'(seg1), 16'h40);

    // Enable drops for three clocks inside a visible slot.
    runTo(7 * FRAME + 11);
    en = 1'b0;
    tick();               checkOutput("enOff_an", 16'(an0), 16'hF);
    tick();
    tick();
    en = 1'b1;
    tick();               checkOutput("enOn_an", 16'(an0), 16'hB);
    runTo(7 * FRAME + 19); checkOutput("enIdx_an", 16'(an0), 16'hD);

    applyStimulus(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 1'b1);
    runTo(7 * FRAME + 21);
    pulseReset();
    runTo(3);             checkOutput("postRst_seg", 16'(seg0), 16'h40); checkOutput("postRst_an", 16'(an0), 16'h7);
    runTo(FRAME + 3);      checkOutput("postRst_load", 16'(seg0), 16'h79);

    for (int v = 0; v < 16; v++) begin
      applyStimulus(tbl[v].digit, 4'h1, 4'h2, 4'h3, tbl[v].dpv, 1'b1);
      runTo((n / FRAME + 1) * FRAME + 5);
      checkOutput("tbl_seg", 16'(seg0), 16'(tbl[v].expSeg));
      checkOutput("tbl_dpn", 16'(dpn0), 16'(tbl[v].expDpN));
    end

    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 19) == 0)
        applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)) & {4{$urandom_range(0, 1) == 1}},
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), en);
      if ($urandom_range(0, 9) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) d1 = 4'h0;
      tick();
      if ($urandom_range(0, 299) == 0) pulseReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
